// File: rtl/scene_pkg.sv
// Shared dimensions, colour type and the fixed 32-entry palette for the scene compositor.
package scene_pkg;

   localparam int MAP_W        = 1024;
   localparam int MAP_H        = 1152;
   localparam int SCR_W        = 640;
   localparam int SCR_H        = 480;
   localparam int CHAR_W       = 19;
   localparam int CHAR_H       = 29;
   localparam int CHAR_FR      = 12;
   localparam int CHAR_X0      = 310;
   localparam int CHAR_Y0      = 226;
   localparam int CHAR_FR_SIZE = CHAR_W * CHAR_H;
   localparam int CAM_X_MAX    = MAP_W - SCR_W;
   localparam int CAM_Y_MAX    = MAP_H - SCR_H;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam logic [4:0] TRANSPARENT_IDX = 5'd0;
   localparam rgb_t       GRID_COLOR      = 24'hFF00FF;

   // Entry i is {8*i, 255-8*i, 8*i+5}.
   localparam rgb_t PALETTE [32] = '{
      24'h00FF05, 24'h08F70D, 24'h10EF15, 24'h18E71D,
      24'h20DF25, 24'h28D72D, 24'h30CF35, 24'h38C73D,
      24'h40BF45, 24'h48B74D, 24'h50AF55, 24'h58A75D,
      24'h609F65, 24'h68976D, 24'h708F75, 24'h78877D,
      24'h807F85, 24'h88778D, 24'h906F95, 24'h98679D,
      24'hA05FA5, 24'hA857AD, 24'hB04FB5, 24'hB847BD,
      24'hC03FC5, 24'hC837CD, 24'hD02FD5, 24'hD827DD,
      24'hE01FE5, 24'hE817ED, 24'hF00FF5, 24'hF807FD
   };

endpackage

// File: rtl/palette_lut.sv
// Registered palette lookup forming the last pipeline stage; blanked pixels come out black.
module palette_lut
   import scene_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] idx,
   input  logic       visible,
   input  logic       grid,
   output rgb_t       rgb
);

   always_ff @(posedge clk) begin
      if (reset || !visible)
         rgb <= '0;
      else if (grid)
         rgb <= GRID_COLOR;
      else
         rgb <= PALETTE[idx];
   end

endmodule

// File: rtl/scene_compositor.sv
// Map/character pixel compositor with 3-cycle latency from DrawX/DrawY/blank to RGB.
// Optional DEBUG_GRID_EN overlays magenta lines every 16 map pixels beneath the character.
module scene_compositor
   import scene_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        blank,
   input  logic        frame_start,
   input  logic [10:0] cam_x,
   input  logic [10:0] cam_y,
   input  logic [3:0]  char_frame,
   output logic [20:0] map_read_address,
   output logic [12:0] char_read_address,
   input  logic [4:0]  map_data,
   input  logic [4:0]  char_data,
   output logic [7:0]  Red,
   output logic [7:0]  Green,
   output logic [7:0]  Blue,
   output logic        blank_out
);

   logic [10:0] cam_x_q, cam_y_q;
   logic [3:0]  frame_q;
   logic [10:0] map_x, map_y;
   logic [9:0]  dx, dy;
   logic        in_char;
   logic        blank_d1, blank_d2;
   logic        in_char_d1, in_char_d2;
   logic        char_opaque;
   logic [4:0]  idx;
   logic        grid;
   rgb_t        rgb;

   // Camera and frame only change at frame boundaries so a frame never tears.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cam_x_q <= '0;
         cam_y_q <= '0;
         frame_q <= '0;
      end else if (frame_start) begin
         cam_x_q <= (cam_x > 11'(CAM_X_MAX)) ? 11'(CAM_X_MAX) : cam_x;
         cam_y_q <= (cam_y > 11'(CAM_Y_MAX)) ? 11'(CAM_Y_MAX) : cam_y;
         frame_q <= (char_frame >= 4'(CHAR_FR)) ? 4'd0 : char_frame;
      end
   end

   assign map_x   = 11'(DrawX) + cam_x_q;
   assign map_y   = 11'(DrawY) + cam_y_q;
   assign dx      = DrawX - 10'(CHAR_X0);
   assign dy      = DrawY - 10'(CHAR_Y0);
   assign in_char = (DrawX >= 10'(CHAR_X0)) && (DrawX < 10'(CHAR_X0 + CHAR_W)) &&
                    (DrawY >= 10'(CHAR_Y0)) && (DrawY < 10'(CHAR_Y0 + CHAR_H));

   // Cleared blank/in_char delays act as the pipeline valid bits after reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         map_read_address  <= '0;
         char_read_address <= '0;
         blank_d1          <= 1'b0;
         blank_d2          <= 1'b0;
         in_char_d1        <= 1'b0;
         in_char_d2        <= 1'b0;
         blank_out         <= 1'b0;
      end else begin
         map_read_address  <= 21'(map_y) * 21'(MAP_W) + 21'(map_x);
         char_read_address <= in_char ? (13'(frame_q) * 13'(CHAR_FR_SIZE) +
                                         13'(dy) * 13'(CHAR_W) + 13'(dx)) : '0;
         blank_d1          <= blank;
         blank_d2          <= blank_d1;
         in_char_d1        <= in_char;
         in_char_d2        <= in_char_d1;
         blank_out         <= blank_d2;
      end
   end

   assign char_opaque = in_char_d2 && (char_data != TRANSPARENT_IDX);
   assign idx         = char_opaque ? char_data : map_data;

`ifdef DEBUG_GRID_EN
   logic grid_d1, grid_d2;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         grid_d1 <= 1'b0;
         grid_d2 <= 1'b0;
      end else begin
         grid_d1 <= (map_x[3:0] == 4'd0) || (map_y[3:0] == 4'd0);
         grid_d2 <= grid_d1;
      end
   end

   assign grid = grid_d2 && !char_opaque;
`else
   assign grid = 1'b0;
`endif

   palette_lut u_palette (
      .clk     (Clk),
      .reset   (Reset),
      .idx     (idx),
      .visible (blank_d2),
      .grid    (grid),
      .rgb     (rgb)
   );

   assign Red   = rgb.r;
   assign Green = rgb.g;
   assign Blue  = rgb.b;

endmodule

// File: tb/tb_scene_compositor.sv
// Directed vector bench for scene_compositor; the grid sequence runs only when DEBUG_GRID_EN is defined.
module tb_scene_compositor;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        blank, frame_start;
   logic [10:0] cam_x, cam_y;
   logic [3:0]  char_frame;
   logic [20:0] map_read_address;
   logic [12:0] char_read_address;
   logic [4:0]  map_data, char_data;
   logic [7:0]  Red, Green, Blue;
   logic        blank_out;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [10:0] cx;
      logic [10:0] cy;
      logic [3:0]  fr;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        bl;
      logic [4:0]  md;
      logic [4:0]  cd;
      logic [20:0] e_map;
      logic [12:0] e_char;
      logic [23:0] e_rgb;
      logic        e_blank;
   } vec_t;

   vec_t vecs [12];

   scene_compositor dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .DrawX             (DrawX),
      .DrawY             (DrawY),
      .blank             (blank),
      .frame_start       (frame_start),
      .cam_x             (cam_x),
      .cam_y             (cam_y),
      .char_frame        (char_frame),
      .map_read_address  (map_read_address),
      .char_read_address (char_read_address),
      .map_data          (map_data),
      .char_data         (char_data),
      .Red               (Red),
      .Green             (Green),
      .Blue              (Blue),
      .blank_out         (blank_out)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic bl,
                                input logic [4:0] md, input logic [4:0] cd);
      DrawX     = x;
      DrawY     = y;
      blank     = bl;
      map_data  = md;
      char_data = cd;
   endtask

   task automatic latchCamera(input logic [10:0] cx, input logic [10:0] cy, input logic [3:0] fr);
      frame_start = 1'b1;
      cam_x       = cx;
      cam_y       = cy;
      char_frame  = fr;
      step();
      frame_start = 1'b0;
   endtask

   initial begin
      //            cx     cy     fr  x    y    bl md  cd  map      char   rgb          blank
      vecs[0]  = '{11'd0,    11'd0,   4'd0,  10'd5,   10'd2,   1'b1, 5'd3,  5'd0,  21'd2053,   13'd0,    24'h18E71D, 1'b1};
      vecs[1]  = '{11'd2000, 11'd900, 4'd0,  10'd0,   10'd0,   1'b0, 5'd9,  5'd0,  21'd688512, 13'd0,    24'h000000, 1'b0};
      vecs[2]  = '{11'd2000, 11'd900, 4'd0,  10'd1,   10'd1,   1'b1, 5'd10, 5'd0,  21'd689537, 13'd0,    24'h50AF55, 1'b1};
      vecs[3]  = '{11'd384,  11'd672, 4'd0,  10'd17,  10'd3,   1'b1, 5'd21, 5'd0,  21'd691601, 13'd0,    24'hA857AD, 1'b1};
      vecs[4]  = '{11'd383,  11'd671, 4'd0,  10'd3,   10'd3,   1'b1, 5'd1,  5'd0,  21'd690562, 13'd0,    24'h08F70D, 1'b1};
      vecs[5]  = '{11'd0,    11'd0,   4'd2,  10'd311, 10'd227, 1'b1, 5'd5,  5'd7,  21'd232759, 13'd1122, 24'h38C73D, 1'b1};
      vecs[6]  = '{11'd0,    11'd0,   4'd2,  10'd311, 10'd227, 1'b1, 5'd5,  5'd0,  21'd232759, 13'd1122, 24'h28D72D, 1'b1};
      vecs[7]  = '{11'd0,    11'd0,   4'd13, 10'd310, 10'd226, 1'b1, 5'd6,  5'd0,  21'd231734, 13'd0,    24'h30CF35, 1'b1};
      vecs[8]  = '{11'd0,    11'd0,   4'd12, 10'd328, 10'd254, 1'b1, 5'd2,  5'd31, 21'd260424, 13'd550,  24'hF807FD, 1'b1};
      vecs[9]  = '{11'd0,    11'd0,   4'd11, 10'd329, 10'd241, 1'b1, 5'd4,  5'd9,  21'd247113, 13'd0,    24'h20DF25, 1'b1};
      vecs[10] = '{11'd0,    11'd0,   4'd11, 10'd318, 10'd225, 1'b1, 5'd8,  5'd3,  21'd230718, 13'd0,    24'h40BF45, 1'b1};
      vecs[11] = '{11'd0,    11'd0,   4'd11, 10'd320, 10'd239, 1'b1, 5'd8,  5'd30, 21'd245056, 13'd6318, 24'hF00FF5, 1'b1};

      Reset       = 1'b1;
      frame_start = 1'b0;
      cam_x       = '0;
      cam_y       = '0;
      char_frame  = '0;
      applyStimulus(10'd100, 10'd100, 1'b1, 5'd7, 5'd7);
      step();
      step();
      checkOutput("reset map_addr", 32'(map_read_address), 32'd0);
      checkOutput("reset char_addr", 32'(char_read_address), 32'd0);
      checkOutput("reset rgb", 32'({Red, Green, Blue}), 32'd0);
      checkOutput("reset blank_out", 32'(blank_out), 32'd0);
      Reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         latchCamera(vecs[i].cx, vecs[i].cy, vecs[i].fr);
         applyStimulus(vecs[i].x, vecs[i].y, vecs[i].bl, vecs[i].md, vecs[i].cd);
         step();
         checkOutput($sformatf("v%0d map_addr", i), 32'(map_read_address), 32'(vecs[i].e_map));
         checkOutput($sformatf("v%0d char_addr", i), 32'(char_read_address), 32'(vecs[i].e_char));
         step();
         step();
         checkOutput($sformatf("v%0d rgb", i), 32'({Red, Green, Blue}), 32'(vecs[i].e_rgb));
         checkOutput($sformatf("v%0d blank_out", i), 32'(blank_out), 32'(vecs[i].e_blank));
      end

      // Mid-stream reset: camera returns to 0 and output stays dark for the pipeline depth.
      Reset = 1'b1;
      applyStimulus(10'd5, 10'd2, 1'b1, 5'd3, 5'd0);
      step();
      Reset = 1'b0;
      step();
      checkOutput("rst+1 map_addr", 32'(map_read_address), 32'd2053);
      checkOutput("rst+1 rgb", 32'({Red, Green, Blue}), 32'd0);
      checkOutput("rst+1 blank_out", 32'(blank_out), 32'd0);
      step();
      checkOutput("rst+2 rgb", 32'({Red, Green, Blue}), 32'd0);
      checkOutput("rst+2 blank_out", 32'(blank_out), 32'd0);
      step();
      checkOutput("rst+3 rgb", 32'({Red, Green, Blue}), 32'h18E71D);
      checkOutput("rst+3 blank_out", 32'(blank_out), 32'd1);

      // Reset beats a simultaneous frame_start.
      Reset       = 1'b1;
      frame_start = 1'b1;
      cam_x       = 11'd100;
      cam_y       = 11'd100;
      step();
      Reset       = 1'b0;
      frame_start = 1'b0;
      applyStimulus(10'd0, 10'd0, 1'b1, 5'd0, 5'd0);
      step();
      checkOutput("reset wins map_addr", 32'(map_read_address), 32'd0);

      // Latch applies only to addresses computed after the pulse cycle.
      frame_start = 1'b1;
      cam_x       = 11'd50;
      cam_y       = 11'd0;
      char_frame  = 4'd0;
      step();
      checkOutput("latch same-cycle map_addr", 32'(map_read_address), 32'd0);
      frame_start = 1'b0;
      step();
      checkOutput("latch next-cycle map_addr", 32'(map_read_address), 32'd50);

      // Blank drop propagates with exact 3-cycle latency.
      applyStimulus(10'd5, 10'd2, 1'b0, 5'd9, 5'd0);
      step();
      step();
      checkOutput("blank lat2 blank_out", 32'(blank_out), 32'd1);
      step();
      checkOutput("blank lat3 rgb", 32'({Red, Green, Blue}), 32'd0);
      checkOutput("blank lat3 blank_out", 32'(blank_out), 32'd0);

`ifdef DEBUG_GRID_EN
      latchCamera(11'd3, 11'd0, 4'd0);
      applyStimulus(10'd13, 10'd5, 1'b1, 5'd2, 5'd0);
      step();
      step();
      step();
      checkOutput("grid line rgb", 32'({Red, Green, Blue}), 32'hFF00FF);
      applyStimulus(10'd317, 10'd230, 1'b1, 5'd2, 5'd4);
      step();
      checkOutput("grid char_addr", 32'(char_read_address), 32'd83);
      step();
      step();
      checkOutput("grid char overlay rgb", 32'({Red, Green, Blue}), 32'h20DF25);
      applyStimulus(10'd317, 10'd230, 1'b1, 5'd2, 5'd0);
      step();
      step();
      step();
      checkOutput("grid transparent char rgb", 32'({Red, Green, Blue}), 32'hFF00FF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
